// File: rtl/divider_const_pipe.sv
// Pipelined unsigned divide-by-constant.
// The quotient is estimated by multiplying with a truncated reciprocal of the
// divisor. That estimate is at most one too small, and a final correction
// stage fixes it, so quotient and remainder are exact for every dividend.
// All stages share one enable, so backpressure freezes the whole pipe.
module divider_const_pipe #(
    parameter  int BWI      = 10,
    parameter  int DIV      = 22,
    parameter  int TAGW     = 1,
    localparam int BWQ      = BWI,
    localparam int CLOG_DIV = $clog2(DIV),
    localparam int BWR      = (CLOG_DIV < 1) ? 1 : CLOG_DIV
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BWI-1:0]  in_data,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BWQ-1:0]  out_quot,
    output logic [BWR-1:0]  out_rem,
    output logic [TAGW-1:0] out_tag
);

    // A zero divisor has no meaning; refuse to elaborate.
    if (DIV < 1) begin : g_div_check
        $error("divider_const_pipe: DIV must be at least 1");
    end

    localparam int         DIV_SAFE = (DIV < 1) ? 1 : DIV;
    localparam int         K        = BWI + CLOG_DIV;
    localparam int         PW       = BWI + K + 1;
    localparam int         EW       = BWI + BWR + 1;
    localparam logic [K:0] POW_K    = {1'b1, {K{1'b0}}};
    localparam logic [K:0] M        = POW_K / (K+1)'(DIV_SAFE);
    localparam logic [BWR:0] DIV_R  = (BWR+1)'(DIV_SAFE);

    // The estimate is q or q-1, so one conditional step of DIV corrects it.
    function automatic logic [BWQ-1:0] fix_quot(input logic [BWQ-1:0] q,
                                                input logic [BWR:0]   r);
        return (r >= DIV_R) ? q + BWQ'(1) : q;
    endfunction

    function automatic logic [BWR-1:0] fix_rem(input logic [BWR:0] r);
        return (r >= DIV_R) ? BWR'(r - DIV_R) : r[BWR-1:0];
    endfunction

    logic            w_en;
    logic [PW-1:0]   w_prod;
    logic [BWQ-1:0]  w_qest;
    logic [BWR:0]    w_rest;

    logic            r_vld_p0, r_vld_p1, r_vld_p2;
    logic [PW-1:0]   r_prod_p0;
    logic [BWI-1:0]  r_x_p0;
    logic [TAGW-1:0] r_tag_p0;
    logic [BWQ-1:0]  r_qest_p1;
    logic [BWR:0]    r_rest_p1;
    logic [TAGW-1:0] r_tag_p1;
    logic [BWQ-1:0]  r_quot_p2;
    logic [BWR-1:0]  r_rem_p2;
    logic [TAGW-1:0] r_tag_p2;

    // The pipe moves whenever the output register is empty or being drained.
    assign w_en     = ~r_vld_p2 | out_ready;
    assign in_ready = w_en;

    assign w_prod = PW'(in_data) * PW'(M);
    assign w_qest = BWQ'(r_prod_p0 >> K);
    // x - q_est*DIV is below 2*DIV, so BWR+1 bits hold it exactly.
    assign w_rest = (BWR+1)'(EW'(r_x_p0) - EW'(w_qest) * EW'(DIV_SAFE));

    // Valid flags: advance together on enable, bubbles included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else if (w_en) begin
            r_vld_p0 <= in_valid;
            r_vld_p1 <= r_vld_p0;
            r_vld_p2 <= r_vld_p1;
        end
    end

    // Inner data stages: unreset, meaning is carried by the valid flags.
    always_ff @(posedge clk) begin
        if (w_en) begin
            // ---- S1: reciprocal multiply ----
            r_prod_p0 <= w_prod;
            r_x_p0    <= in_data;
            r_tag_p0  <= in_tag;
            // ---- S2: quotient and remainder estimate ----
            r_qest_p1 <= w_qest;
            r_rest_p1 <= w_rest;
            r_tag_p1  <= r_tag_p0;
        end
    end

    // ---- S3: correction; these registers drive the outputs directly ----
    // Output registers: cleared on reset so outputs are zero while held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quot_p2 <= '0;
            r_rem_p2  <= '0;
            r_tag_p2  <= '0;
        end else if (w_en) begin
            r_quot_p2 <= fix_quot(r_qest_p1, r_rest_p1);
            r_rem_p2  <= fix_rem(r_rest_p1);
            r_tag_p2  <= r_tag_p1;
        end
    end

    assign out_valid = r_vld_p2;
    assign out_quot  = r_quot_p2;
    assign out_rem   = r_rem_p2;
    assign out_tag   = r_tag_p2;

endmodule

// File: tb/tb_divider_const_pipe.sv
// Bench for divider_const_pipe: one default-width instance with a queue
// reference model, a BWI=5 sweep instance and three divisor-corner instances.
module tb_divider_const_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance A: BWI=10, DIV=22, TAGW=3 ----------------
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [9:0] a_in_data, a_out_quot;
    logic [2:0] a_in_tag, a_out_tag;
    logic [4:0] a_out_rem;

    divider_const_pipe #(.BWI(10), .DIV(22), .TAGW(3)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_quot(a_out_quot), .out_rem(a_out_rem), .out_tag(a_out_tag)
    );

    // ---------------- instance B: BWI=5, DIV=22, TAGW=4 ----------------
    logic       b_in_valid, b_in_ready, b_out_valid;
    logic [4:0] b_in_data, b_out_quot, b_out_rem;
    logic [3:0] b_in_tag, b_out_tag;

    divider_const_pipe #(.BWI(5), .DIV(22), .TAGW(4)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(1'b1),
        .out_quot(b_out_quot), .out_rem(b_out_rem), .out_tag(b_out_tag)
    );

    // ------------- corner instances C (DIV=1), D (DIV=16), E (DIV=1023) -------------
    logic       c_in_valid;
    logic [9:0] c_in_data;
    logic [0:0] c_in_tag;
    logic       c_in_ready, c_out_valid, d_in_ready, d_out_valid, e_in_ready, e_out_valid;
    logic [9:0] c_out_quot, d_out_quot, e_out_quot;
    logic [0:0] c_out_rem;
    logic [3:0] d_out_rem;
    logic [9:0] e_out_rem;
    logic [0:0] c_out_tag, d_out_tag, e_out_tag;

    divider_const_pipe #(.BWI(10), .DIV(1), .TAGW(1)) u_c (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_tag(c_in_tag),
        .out_valid(c_out_valid), .out_ready(1'b1),
        .out_quot(c_out_quot), .out_rem(c_out_rem), .out_tag(c_out_tag)
    );

    divider_const_pipe #(.BWI(10), .DIV(16), .TAGW(1)) u_d (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_in_valid), .in_ready(d_in_ready),
        .in_data(c_in_data), .in_tag(c_in_tag),
        .out_valid(d_out_valid), .out_ready(1'b1),
        .out_quot(d_out_quot), .out_rem(d_out_rem), .out_tag(d_out_tag)
    );

    divider_const_pipe #(.BWI(10), .DIV(1023), .TAGW(1)) u_e (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_in_valid), .in_ready(e_in_ready),
        .in_data(c_in_data), .in_tag(c_in_tag),
        .out_valid(e_out_valid), .out_ready(1'b1),
        .out_quot(e_out_quot), .out_rem(e_out_rem), .out_tag(e_out_tag)
    );

    // ---------------- reference model for instance A ----------------
    typedef struct packed {
        logic [9:0] x;
        logic [2:0] tag;
    } op_t;

    op_t        q_a[$];
    int         a_emits = 0;
    logic       a_prev_stall = 1'b0;
    logic [9:0] a_pq;
    logic [4:0] a_pr;
    logic [2:0] a_pt;
    op_t        a_exp;

    // Sampled on the falling edge: handshakes seen here complete on the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            a_prev_stall = 1'b0;
        end else begin
            check_val("a_in_ready", 32'(a_in_ready), 32'(!a_out_valid || a_out_ready));
            if (a_prev_stall) begin
                check_val("a_stall_valid", 32'(a_out_valid), 32'd1);
                check_val("a_stall_quot", 32'(a_out_quot), 32'(a_pq));
                check_val("a_stall_rem", 32'(a_out_rem), 32'(a_pr));
                check_val("a_stall_tag", 32'(a_out_tag), 32'(a_pt));
            end
            if (a_out_valid && a_out_ready) begin
                if (q_a.size() == 0) begin
                    check_val("a_spurious_valid", 32'(a_out_valid), 32'd0);
                end else begin
                    a_exp = q_a.pop_front();
                    check_val("a_quot", 32'(a_out_quot), 32'(int'(a_exp.x) / 22));
                    check_val("a_rem", 32'(a_out_rem), 32'(int'(a_exp.x) % 22));
                    check_val("a_tag", 32'(a_out_tag), 32'(a_exp.tag));
                    a_emits++;
                end
            end
            if (a_in_valid && a_in_ready)
                q_a.push_back('{x: a_in_data, tag: a_in_tag});
            a_prev_stall = a_out_valid && !a_out_ready;
            a_pq = a_out_quot;
            a_pr = a_out_rem;
            a_pt = a_out_tag;
        end
    end

    task automatic send_a(input logic [9:0] x, input logic [2:0] t);
        int  guard;
        bit  done;
        guard = 0;
        done  = 1'b0;
        a_in_valid = 1'b1;
        a_in_data  = x;
        a_in_tag   = t;
        while (!done) begin
            @(negedge clk);
            done = a_in_ready;
            tick();
            guard++;
            if (!done && guard > 200) begin
                check_val("a_send_timeout", 32'(a_in_ready), 32'd1);
                break;
            end
        end
        a_in_valid = 1'b0;
    endtask

    task automatic drain_a();
        int guard;
        guard = 0;
        while (q_a.size() != 0 && guard < 100) begin
            tick();
            guard++;
        end
        check_val("a_drain_left", 32'(q_a.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        int          xs[6];
        int          eq[6];
        int          er[6];
        logic [3:0]  btag[32];
        int          cx[8];
        int          base;
        logic [9:0]  bp_x[8];
        logic [2:0]  bp_t[8];

        xs = '{0, 21, 22, 1023, 1012, 1011};
        eq = '{0, 0, 1, 46, 46, 45};
        er = '{0, 21, 0, 11, 0, 21};

        rst_n = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_in_tag = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_tag = '0;
        c_in_valid = 1'b0; c_in_data = '0; c_in_tag = '0;

        // ---- reset state ----
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_out_valid", 32'(a_out_valid), 32'd0);
        check_val("rst_out_quot", 32'(a_out_quot), 32'd0);
        check_val("rst_out_rem", 32'(a_out_rem), 32'd0);
        check_val("rst_out_tag", 32'(a_out_tag), 32'd0);
        check_val("rst_in_ready", 32'(a_in_ready), 32'd1);
        check_val("rst_b_valid", 32'(b_out_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_val("post_rst_in_ready", 32'(a_in_ready), 32'd1);
        check_val("post_rst_valid", 32'(a_out_valid), 32'd0);

        // ---- directed stream with 3-edge latency ----
        a_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i < 6) begin
                a_in_valid = 1'b1;
                a_in_data  = 10'(xs[i]);
                a_in_tag   = 3'(i);
            end else begin
                a_in_valid = 1'b0;
            end
            tick();
            if (i >= 2) begin
                check_val("dir_valid", 32'(a_out_valid), 32'd1);
                check_val("dir_quot", 32'(a_out_quot), 32'(eq[i-2]));
                check_val("dir_rem", 32'(a_out_rem), 32'(er[i-2]));
                check_val("dir_tag", 32'(a_out_tag), 32'(i-2));
            end else begin
                check_val("dir_latency_valid", 32'(a_out_valid), 32'd0);
            end
        end
        drain_a();

        // ---- exhaustive BWI=5 sweep ----
        for (int i = 0; i < 34; i++) begin
            if (i < 32) begin
                btag[i]    = 4'($urandom_range(0, 15));
                b_in_valid = 1'b1;
                b_in_data  = 5'(i);
                b_in_tag   = btag[i];
            end else begin
                b_in_valid = 1'b0;
            end
            tick();
            check_val("b_in_ready", 32'(b_in_ready), 32'd1);
            if (i >= 2) begin
                check_val("b_valid", 32'(b_out_valid), 32'd1);
                check_val("b_quot", 32'(b_out_quot), 32'((i-2) / 22));
                check_val("b_rem", 32'(b_out_rem), 32'((i-2) % 22));
                check_val("b_tag", 32'(b_out_tag), 32'(btag[i-2]));
            end
        end

        // ---- divisor corners: DIV = 1, 16, 1023 ----
        cx = '{1023, 1022, 0, 16, 15, 1, 0, 0};
        cx[6] = int'($urandom_range(0, 1023));
        cx[7] = int'($urandom_range(0, 1023));
        for (int k = 0; k < 8; k++) begin
            c_in_valid = 1'b1;
            c_in_data  = 10'(cx[k]);
            c_in_tag   = 1'(k);
            tick();
            c_in_valid = 1'b0;
            tick();
            tick();
            check_val("c_valid", 32'(c_out_valid), 32'd1);
            check_val("c_quot", 32'(c_out_quot), 32'(cx[k]));
            check_val("c_rem", 32'(c_out_rem), 32'd0);
            check_val("c_tag", 32'(c_out_tag), 32'(k % 2));
            check_val("d_valid", 32'(d_out_valid), 32'd1);
            check_val("d_quot", 32'(d_out_quot), 32'(cx[k] / 16));
            check_val("d_rem", 32'(d_out_rem), 32'(cx[k] % 16));
            check_val("e_valid", 32'(e_out_valid), 32'd1);
            check_val("e_quot", 32'(e_out_quot), 32'(cx[k] / 1023));
            check_val("e_rem", 32'(e_out_rem), 32'(cx[k] % 1023));
            check_val("e_tag", 32'(e_out_tag), 32'(k % 2));
            check_val("cde_in_ready", 32'({c_in_ready, d_in_ready, e_in_ready}), 32'd7);
            tick();
        end

        // ---- backpressure: 8 operands, 5-cycle stall ----
        for (int k = 0; k < 8; k++) begin
            bp_x[k] = 10'($urandom_range(0, 1023));
            bp_t[k] = 3'($urandom_range(0, 7));
        end
        base = a_emits;
        a_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) send_a(bp_x[k], bp_t[k]);
        a_in_valid = 1'b1;
        a_in_data  = bp_x[3];
        a_in_tag   = bp_t[3];
        for (int s = 0; s < 5; s++) begin
            check_val("bp_in_ready", 32'(a_in_ready), 32'd0);
            check_val("bp_out_valid", 32'(a_out_valid), 32'd1);
            check_val("bp_quot", 32'(a_out_quot), 32'(int'(bp_x[0]) / 22));
            check_val("bp_rem", 32'(a_out_rem), 32'(int'(bp_x[0]) % 22));
            check_val("bp_tag", 32'(a_out_tag), 32'(bp_t[0]));
            tick();
        end
        a_out_ready = 1'b1;
        for (int k = 3; k < 8; k++) send_a(bp_x[k], bp_t[k]);
        drain_a();
        check_val("bp_emit_count", 32'(a_emits - base), 32'd8);

        // ---- bubbles with random out_ready ----
        base = a_emits;
        for (int i = 0; i < 60; i++) begin
            a_in_valid  = (i % 2) == 0;
            a_in_data   = 10'($urandom_range(0, 1023));
            a_in_tag    = 3'($urandom_range(0, 7));
            a_out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        drain_a();
        tick();
        check_val("bub_idle_valid", 32'(a_out_valid), 32'd0);

        // ---- reset mid-stream ----
        a_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_in_valid = 1'b1;
            a_in_data  = 10'(100 + 7 * k);
            a_in_tag   = 3'(k);
            tick();
        end
        a_in_valid = 1'b0;
        check_val("mid_valid_before_rst", 32'(a_out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        q_a.delete();
        check_val("mid_rst_valid", 32'(a_out_valid), 32'd0);
        check_val("mid_rst_quot", 32'(a_out_quot), 32'd0);
        check_val("mid_rst_rem", 32'(a_out_rem), 32'd0);
        check_val("mid_rst_tag", 32'(a_out_tag), 32'd0);
        check_val("mid_rst_in_ready", 32'(a_in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            tick();
            check_val("mid_no_ghost", 32'(a_out_valid), 32'd0);
        end
        a_in_valid = 1'b1;
        a_in_data  = 10'd44;
        a_in_tag   = 3'd5;
        tick();
        a_in_valid = 1'b0;
        check_val("mid_lat0", 32'(a_out_valid), 32'd0);
        tick();
        check_val("mid_lat1", 32'(a_out_valid), 32'd0);
        tick();
        check_val("mid_valid", 32'(a_out_valid), 32'd1);
        check_val("mid_quot", 32'(a_out_quot), 32'd2);
        check_val("mid_rem", 32'(a_out_rem), 32'd0);
        check_val("mid_tag", 32'(a_out_tag), 32'd5);
        drain_a();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/divider_const_pipe.md
# divider_const_pipe

Pipelined unsigned divider by a compile-time constant. It computes quotient and remainder of an unsigned dividend by a fixed divisor. The division uses reciprocal multiplication with a correction stage, so results are exact for every input value. Width, divisor and sideband tag width are parameters. The block sits on streaming datapaths with a valid/ready handshake and full backpressure, and it replaces the earlier combinational constant-divider blocks.

## Interface
- BWI, 10, dividend width in bits (≥1).
- DIV, 22, constant divisor (≥1; elaboration error if 0).
- TAGW, 1, width of the sideband tag carried alongside each operand (≥1).
- Derived (localparams, not overridable):
  - BWQ = BWI, quotient width.
  - BWR = max(1, clog2(DIV)), remainder width.
  - K = BWI + clog2(DIV).
  - M = floor(2^K / DIV), reciprocal constant of K+1 bits.
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  reset, asynchronous assert, active-low; deassertion synchronised externally.
- in_valid  input  1  dividend and tag are valid.
- in_ready  output  1  block accepts the operand this cycle.
- in_data  input  BWI  unsigned dividend x.
- in_tag  input  TAGW  opaque sideband value, returned unchanged with the result.
- out_valid  output  1  quotient, remainder and tag are valid.
- out_ready  input  1  downstream accepts the result this cycle.
- out_quot  output  BWQ  floor(x / DIV).
- out_rem  output  BWR  x mod DIV.
- out_tag  output  TAGW  in_tag of the same operand.

## Operation
- Three registered stages: S1 multiply, S2 remainder estimate, S3 correction/output. Each stage has a valid flag plus data registers.
- S1 latches:
  - p = x·M (BWI+K+1 bits)
  - x
  - tag
- S2 latches:
  - q_est = p >> K
  - r_est = x − q_est·DIV, held with BWR+1 bits
  - tag
- Error bound: q_est ∈ {q−1, q}, so 0 ≤ r_est < 2·DIV.
- S3 latches the corrected result:
  - if r_est ≥ DIV: quot = q_est+1, rem = r_est−DIV.
  - else: quot = q_est, rem = r_est[BWR-1:0].
  - tag passes through.
- S3 registers drive the outputs directly. There is no combinational path from in_* to out_*.
- DIV=1: M = 2^K, quot = x, rem = 0, and the correction never fires.
- DIV a power of two: the result is still exact. No special-case logic is required.
- Global pipeline enable en = ~out_valid | out_ready. in_ready = en.
- When en=1, all stages advance one step:
  - S1.valid ← in_valid
  - S2.valid ← S1.valid
  - S3.valid ← S2.valid
- When en=0, all stage registers hold.
- Bubbles are not collapsed; an empty stage advances like a full one.
- Data registers may load on en regardless of valid. Only the valid flags carry meaning.
- Results leave in strict input order; no operand is dropped or duplicated.

## Timing
- Reset (rst_n=0, asynchronous):
  - all stage valid flags = 0
  - out_valid = 0, out_quot = 0, out_rem = 0, out_tag = 0
  - in_ready = 1 during reset and immediately after
- Reset mid-operation discards every in-flight operand; nothing is emitted after release until new inputs arrive.
- Handshake rules:
  - An input transfer occurs when in_valid & in_ready at a rising edge.
  - An output transfer occurs when out_valid & out_ready at a rising edge.
- Latency: an operand accepted at edge n appears with out_valid=1 after edge n+2. It is first presentable in the cycle following edge n+2.
- Throughput: one result per cycle while out_ready=1.
- Stall: out_valid=1 & out_ready=0 holds all outputs stable and drives in_ready=0 in the same cycle (combinational from out_valid/out_ready).
- Output stability: out_quot, out_rem and out_tag may change only on an edge where out_valid=0 or an output transfer occurs.
- Simultaneous events: with out_ready=1 and out_valid=1, in_ready=1, so an accept and an emit happen on the same edge.
- in_valid dropping mid-stream inserts bubbles. out_valid is 0 for the corresponding cycles.

## Test plan
- Defaults, streaming. Inputs x = 0, 21, 22, 1023, 1012, 1011, in_ready/out_ready held 1 → outputs (quot, rem) = (0,0), (0,21), (1,0), (46,11), (46,0), (45,21). First out_valid comes 3 edges after the first accept, then results are back to back.
- Exhaustive sweep, BWI=5, DIV=22. All x = 0..31 with random tags → quot/rem match x/22 and x%22 (e.g. 31 → 1, 9), tags are preserved, and the correction branch is hit at least once.
- Parameter corners: DIV=1 (x=1023 → 1023, 0) and DIV=16 (x=1023 → 63, 15). Also DIV=1023 with BWI=10 (1023 → 1, 0; 1022 → 0, 1022).
- Backpressure: stream 8 operands, then hold out_ready=0 for 5 cycles while out_valid=1 → in_ready=0 throughout and outputs are frozen. After release, all 8 results emerge in order with no loss or duplication.
- Bubbles and simultaneous accept/emit: alternate in_valid 1/0 with random out_ready → the valid pattern is preserved, and there are no spurious out_valid pulses.
- Reset mid-stream: assert rst_n=0 asynchronously with 3 operands in flight → out_valid=0 and all outputs are 0 at once. No in-flight result appears after release, and a new x=44 yields (2, 0) with the same 3-edge latency.
